rx_payload_checker: RTL

//  Receive-side counterpart of the GTXE2 payload generator. Sits on the RX fabric side (RXUSRCLK2

---
 rtl/rx_payload_checker_pkg.sv | 19 +
 rtl/rx_payload_checker_sat_counter.sv | 24 ++
 rtl/rx_payload_checker.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/rx_payload_checker_pkg.sv
// Shared definitions for the RX payload checker.
//   - FSM state codes, which are also the values driven on the 'state' debug output
//   - K28_5: the default comma byte
//   - idx_width(): width of the payload byte index; a one-byte pattern still gets a 1-bit index
package rx_payload_checker_pkg;

  localparam logic [2:0] S_INIT  = 3'd0;
  localparam logic [2:0] S_WAKE  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_HUNT  = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;

  localparam logic [7:0] K28_5 = 8'hBC;

  function automatic int idx_width(input int pat_len);
    return (pat_len > 1) ? $clog2(pat_len) : 1;
  endfunction

endpackage

// File: rtl/rx_payload_checker_sat_counter.sv
// sat_counter: up-counter that stops at all-ones instead of wrapping.
// Ports:
//   clk   in  1  clock
//   reset in  1  asynchronous, active-high; clears the count
//   inc   in  1  count enable, one step per cycle
//   cnt   out W  current count
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/rx_payload_checker.sv
// rx_payload_checker: RX-side checker for comma-delimited payload frames.
// Optionally follows the OOB sequence (COMINIT then COMWAKE), waits for byte
// alignment, hunts for a comma and checks the PAT_LEN bytes after it against
// PATTERN (most significant byte first).
//
// Build option: define RX_CHECK_OOB_EN to build the S_INIT/S_WAKE OOB stages.
// Without it reset enters S_ALIGN and the OOB detect inputs are unused.
//
// Ports:
//   clk, reset                       RX user clock; asynchronous active-high reset
//   rx_data, rx_charisk              decoded byte and its K-character flag
//   rx_disperr, rx_notintable        8b10b code error flags
//   rx_byteisaligned                 byte alignment status
//   rx_cominitdet, rx_comwakedet     OOB detect strobes
//   state                            current FSM state code (see package)
//   synced                           set once a comma has been seen since alignment
//   frame_ok, frame_err              one-cycle frame result pulses
//   good_frames, bad_frames          saturating frame counters
//   code_errs                        saturating count of cycles with code errors
//
// Handshake: there is no backpressure. One byte is accepted on every clock
// edge; a result pulse is a one-cycle strobe, valid for exactly the cycle it is high.
module rx_payload_checker
  import rx_payload_checker_pkg::*;
#(
  parameter int          PAT_LEN = 4,
  parameter logic [63:0] PATTERN = 64'hDEADBEEF,
  parameter logic [7:0]  COMMA   = K28_5,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_charisk,
  input  logic             rx_disperr,
  input  logic             rx_notintable,
  input  logic             rx_byteisaligned,
  input  logic             rx_cominitdet,
  input  logic             rx_comwakedet,
  output logic [2:0]       state,
  output logic             synced,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [CNT_W-1:0] good_frames,
  output logic [CNT_W-1:0] bad_frames,
  output logic [CNT_W-1:0] code_errs
);

  localparam int             IDX_W    = idx_width(PAT_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PAT_LEN - 1);

`ifdef RX_CHECK_OOB_EN
  localparam logic [2:0] RESET_STATE = S_INIT;
`else
  localparam logic [2:0] RESET_STATE = S_ALIGN;
  logic unused_oob;
  assign unused_oob = rx_cominitdet | rx_comwakedet;
`endif

  logic [IDX_W-1:0] idx, idx_d;
  logic             bad, bad_d;
  logic [2:0]       state_d;
  logic             synced_d;
  logic             ok_d, err_d;
  logic [7:0]       exp_byte;
  logic             is_comma;
  logic             code_err;
  logic             byte_bad;
  logic             code_inc;

  assign is_comma = rx_charisk && (rx_data == COMMA);
  assign code_err = rx_disperr | rx_notintable;

  // Expected byte for the current index; byte 0 is the most significant
  // byte of the low PAT_LEN bytes of PATTERN.
  always_comb begin
    exp_byte = '0;
    for (int i = 0; i < PAT_LEN; i++) begin
      if (idx == i[IDX_W-1:0]) exp_byte = PATTERN[8*(PAT_LEN-1-i) +: 8];
    end
  end

  // A K-character inside the payload is always an error, even if its
  // value happens to match.
  assign byte_bad = (rx_data != exp_byte) | rx_charisk | code_err;

  always_comb begin
    state_d  = state;
    idx_d    = idx;
    bad_d    = bad;
    synced_d = synced;
    ok_d     = 1'b0;
    err_d    = 1'b0;
    case (state)
`ifdef RX_CHECK_OOB_EN
      // COMWAKE arriving together with COMINIT is not honoured here: the
      // wake has to be seen again once in S_WAKE.
      S_INIT: if (rx_cominitdet) state_d = S_WAKE;
      S_WAKE: if (rx_comwakedet) state_d = S_ALIGN;
`endif
      S_ALIGN: begin
        synced_d = 1'b0;
        if (rx_byteisaligned) state_d = S_HUNT;
      end
      S_HUNT: begin
        if (!rx_byteisaligned) begin
          state_d  = S_ALIGN;
          synced_d = 1'b0;
        end else if (is_comma) begin
          state_d  = S_DATA;
          idx_d    = '0;
          bad_d    = 1'b0;
          synced_d = 1'b1;
        end
      end
      S_DATA: begin
        if (!rx_byteisaligned) begin
          // Losing alignment abandons the partial frame.
          state_d  = S_ALIGN;
          synced_d = 1'b0;
          err_d    = 1'b1;
        end else if (is_comma) begin
          // Early comma: fail the partial frame and restart on this comma.
          err_d = 1'b1;
          idx_d = '0;
          bad_d = 1'b0;
        end else if (idx == LAST_IDX) begin
          ok_d    = !(bad | byte_bad);
          err_d   = bad | byte_bad;
          state_d = S_HUNT;
          idx_d   = '0;
          bad_d   = 1'b0;
        end else begin
          idx_d = idx + 1'b1;
          bad_d = bad | byte_bad;
        end
      end
      default: begin
        state_d  = RESET_STATE;
        synced_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RESET_STATE;
      idx       <= '0;
      bad       <= 1'b0;
      synced    <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_d;
      idx       <= idx_d;
      bad       <= bad_d;
      synced    <= synced_d;
      frame_ok  <= ok_d;
      frame_err <= err_d;
    end
  end

  assign code_inc = code_err &&
                    ((state == S_ALIGN) || (state == S_HUNT) || (state == S_DATA));

  // Counters take the same next-cycle values as the pulse registers so a
  // count changes on the edge its pulse rises.
  sat_counter #(.W(CNT_W)) u_good_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ok_d),
    .cnt   (good_frames)
  );

  sat_counter #(.W(CNT_W)) u_bad_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_d),
    .cnt   (bad_frames)
  );

  sat_counter #(.W(CNT_W)) u_code_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (code_inc),
    .cnt   (code_errs)
  );

endmodule
